icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 4, number of cache lines is 2^INDEX_BITS; one 32-bit word per line.
REQ-002 clk_in  input  1  single clock, all state updates on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low.
REQ-004 rdy_in  input  1  global enable; when low all state SHALL hold.
REQ-005 rob_clear  input  1  pipeline flush; cancels delivery of any in-flight fetch.
REQ-006 if_req  input  1  fetch request from instruction fetch, held until if_valid or rob_clear.
REQ-007 if_addr  input  32  fetch PC, word aligned, bits [1:0] ignored.
REQ-008 if_valid  output  1  one-cycle pulse, if_inst valid for the current request.
REQ-009 if_inst  output  32  fetched instruction word.
REQ-010 ic_mem_ask  output  1  miss request to memory controller, level, held until ic_mem_valid.
REQ-011 ic_mem_addr  output  32  word address of the miss, stable while ic_mem_ask is high.
REQ-012 ic_mem_valid  input  1  one-cycle pulse from memory controller, ic_mem_inst valid.
REQ-013 ic_mem_inst  input  32  little-endian word returned by memory controller.

Function
REQ-014 Address split: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2]; storage per line: valid bit, tag, data word.
REQ-015 States: IDLE, MISS, plus registered delivery; only IDLE accepts if_req.
REQ-016 IDLE, if_req high, line valid and tag equal (hit): next edge if_valid=1, if_inst=line data, stay IDLE; hit latency exactly 1 cycle.
REQ-017 IDLE, if_req high, miss: next edge ic_mem_ask=1, ic_mem_addr={if_addr[31:2],2'b00}, latch index/tag, go to MISS; if_valid stays 0.
REQ-018 MISS: ic_mem_ask and ic_mem_addr held unchanged every cycle until ic_mem_valid, regardless of how long the controller serves other requesters.
REQ-019 MISS, ic_mem_valid=1: next edge write line (valid=1, latched tag, ic_mem_inst), ic_mem_ask=0, if_valid=1, if_inst=ic_mem_inst, go IDLE.
REQ-020 ic_mem_ask SHALL be low in the cycle following ic_mem_valid, so the controller's pause cycle never sees a stale request; a new miss may raise it again the cycle after that at earliest.
REQ-021 if_valid SHALL be a single-cycle pulse; if_req arriving in the delivery cycle is treated as a new request.
REQ-022 rob_clear in IDLE: current lookup suppressed, if_valid=0 next edge.
REQ-023 rob_clear in MISS: fetch is not aborted (controller cannot abort); state moves to MISS with a drop flag set; on ic_mem_valid the line is still filled but if_valid stays 0.
REQ-024 rob_clear coincident with ic_mem_valid: line filled, if_valid=0, go IDLE.
REQ-025 rob_clear does not invalidate any cache line.
REQ-026 if_req while in MISS is ignored; IF holds it until served.
REQ-027 rdy_in low: no state, line, or output changes; ic_mem_valid pulses occur only with rdy_in high.

Reset
REQ-028 rst_in low: all valid bits 0, state IDLE, drop flag 0, if_valid=0, if_inst=0, ic_mem_ask=0, ic_mem_addr=0, immediately and independent of clk_in.
REQ-029 Reset mid-MISS abandons the miss; after release the cache is empty and no fill from the abandoned miss is written.
REQ-030 Data and tag arrays need not be reset; only valid bits.

Structure
REQ-031 State encodings and default INDEX_BITS live in the shared constants include alongside the opcode defines.
REQ-032 Single module, no sub-modules; arrays implemented as register arrays.

Verification
REQ-033 Cold miss: if_req, if_addr=0x0000_0010, memory returns 0x0010_0093 after 6 cycles -> ic_mem_ask high with addr 0x10 until valid, if_valid pulse with if_inst=0x0010_0093, ask low next cycle.
REQ-034 Hit: repeat 0x10 -> if_valid one cycle after if_req, no ic_mem_ask.
REQ-035 Conflict: 0x10 then 0x50 (same index, INDEX_BITS=4) -> second misses, refill; then 0x10 misses again.
REQ-036 Flush in MISS: if_req 0x20, rob_clear 2 cycles later, valid returns 0x0000_0013 -> no if_valid; later 0x20 hits with 0x0000_0013.
REQ-037 Long wait: controller delays valid 20 cycles -> ic_mem_ask and ic_mem_addr unchanged all 20 cycles; rdy_in low 3 cycles mid-MISS -> no output change.
REQ-038 Reset mid-MISS: assert rst_in low asynchronously -> ask drops at once; after release 0x10 misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared constants for the instruction cache: default geometry and FSM state encoding.
package icache_pkg;

   // Default number of index bits (2^4 = 16 single-word lines).
   localparam int unsigned IC_INDEX_BITS = 4;

   typedef enum logic [0:0] {
      StIdle,
      StMiss
   } ic_state_e;

endpackage

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, single outstanding miss.
// Outputs are registered; a fetch in flight when the pipeline flushes is still
// written into the array but its delivery is suppressed.
module icache
   import icache_pkg::*;
#(
   parameter int unsigned INDEX_BITS = IC_INDEX_BITS
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        rob_clear,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic        ic_mem_ask,
   output logic [31:0] ic_mem_addr,
   input  logic        ic_mem_valid,
   input  logic [31:0] ic_mem_inst
);

   localparam int unsigned LINES    = 1 << INDEX_BITS;
   localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

   // Line storage: only the valid bits are reset.
   logic [LINES-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES];

   ic_state_e           state_q, state_d;
   logic                drop_q, drop_d;
   logic [INDEX_BITS-1:0] idx_q, idx_d;
   logic [TAG_BITS-1:0] tag_q, tag_d;
   logic                if_valid_q, if_valid_d;
   logic [31:0]         if_inst_q, if_inst_d;
   logic                ask_q, ask_d;
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic                fill_en;

   logic [INDEX_BITS-1:0] req_idx;
   logic [TAG_BITS-1:0]   req_tag;
   logic                  hit;

   assign req_idx = if_addr[INDEX_BITS+1:2];
   assign req_tag = if_addr[31:INDEX_BITS+2];
   assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

   assign if_valid    = if_valid_q;
   assign if_inst     = if_inst_q;
   assign ic_mem_ask  = ask_q;
   assign ic_mem_addr = mem_addr_q;

   // Next-state and output decode; if_valid defaults low so it only ever pulses.
   always_comb begin
      state_d    = state_q;
      drop_d     = drop_q;
      idx_d      = idx_q;
      tag_d      = tag_q;
      if_valid_d = 1'b0;
      if_inst_d  = if_inst_q;
      ask_d      = ask_q;
      mem_addr_d = mem_addr_q;
      fill_en    = 1'b0;
      unique case (state_q)
         StIdle: begin
            // A flush in the lookup cycle cancels both the hit and a new miss.
            if (if_req && !rob_clear) begin
               if (hit) begin
                  if_valid_d = 1'b1;
                  if_inst_d  = data_mem[req_idx];
               end else begin
                  ask_d      = 1'b1;
                  mem_addr_d = {if_addr[31:2], 2'b00};
                  idx_d      = req_idx;
                  tag_d      = req_tag;
                  drop_d     = 1'b0;
                  state_d    = StMiss;
               end
            end
         end
         StMiss: begin
            if (ic_mem_valid) begin
               // The controller cannot abort, so the line is filled even when dropped.
               fill_en = 1'b1;
               ask_d   = 1'b0;
               drop_d  = 1'b0;
               state_d = StIdle;
               if (!(drop_q || rob_clear)) begin
                  if_valid_d = 1'b1;
                  if_inst_d  = ic_mem_inst;
               end
            end else if (rob_clear) begin
               drop_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control and output registers; everything holds while rdy_in is low.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= StIdle;
         drop_q     <= 1'b0;
         idx_q      <= '0;
         tag_q      <= '0;
         if_valid_q <= 1'b0;
         if_inst_q  <= '0;
         ask_q      <= 1'b0;
         mem_addr_q <= '0;
         valid_q    <= '0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         drop_q     <= drop_d;
         idx_q      <= idx_d;
         tag_q      <= tag_d;
         if_valid_q <= if_valid_d;
         if_inst_q  <= if_inst_d;
         ask_q      <= ask_d;
         mem_addr_q <= mem_addr_d;
         if (fill_en) begin
            valid_q[idx_q] <= 1'b1;
         end
      end
   end

   // Tag and data arrays carry no reset; the valid bits gate their use.
   always_ff @(posedge clk_in) begin
      if (rdy_in && fill_en) begin
         tag_mem[idx_q]  <= tag_q;
         data_mem[idx_q] <= ic_mem_inst;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches,
// checked against a line-level model of a direct-mapped cache.
module tb_icache;

   localparam int unsigned IB = 4;
   localparam int unsigned NL = 1 << IB;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        rob_clear;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [31:0] if_inst;
   logic        ic_mem_ask;
   logic [31:0] ic_mem_addr;
   logic        ic_mem_valid;
   logic [31:0] ic_mem_inst;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: per line valid/tag/data, plus backing memory contents.
   bit          mv [NL];
   logic [29-IB:0] mt [NL];
   logic [31:0] md [NL];
   logic [31:0] mem_word [logic [31:0]];

   icache #(.INDEX_BITS(IB)) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .rdy_in      (rdy_in),
      .rob_clear   (rob_clear),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_valid    (if_valid),
      .if_inst     (if_inst),
      .ic_mem_ask  (ic_mem_ask),
      .ic_mem_addr (ic_mem_addr),
      .ic_mem_valid(ic_mem_valid),
      .ic_mem_inst (ic_mem_inst)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] get_word(input logic [31:0] a);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      if (!mem_word.exists(wa)) mem_word[wa] = $urandom;
      return mem_word[wa];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NL; i++) mv[i] = 1'b0;
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // One fetch from IDLE. delay: cycles the controller waits before ic_mem_valid;
   // flush_at: miss-loop cycle carrying rob_clear (-1 none); rdy_at: cycle where
   // rdy_in drops for 3 cycles (-1 none).
   task automatic do_fetch(input logic [31:0] addr, input int delay, input int flush_at,
                           input int rdy_at, input string name);
      int unsigned idx;
      logic [29-IB:0] tag;
      logic [31:0] word, waddr;
      bit hit, dropped;
      idx   = addr[IB+1:2];
      tag   = addr[31:IB+2];
      word  = get_word(addr);
      waddr = {addr[31:2], 2'b00};
      hit   = mv[idx] && (mt[idx] == tag);
      if_req  = 1'b1;
      if_addr = addr;
      step();
      if (hit) begin
         n_tests++;
         if (if_valid !== 1'b1 || if_inst !== md[idx] || ic_mem_ask !== 1'b0) begin
            n_fail++;
            $display("FAIL %s hit: valid=%b inst=%h ask=%b, want valid=1 inst=%h ask=0",
                     name, if_valid, if_inst, ic_mem_ask, md[idx]);
         end
         if_req = 1'b0;
      end else begin
         n_tests++;
         if (if_valid !== 1'b0 || ic_mem_ask !== 1'b1 || ic_mem_addr !== waddr) begin
            n_fail++;
            $display("FAIL %s miss_start: valid=%b ask=%b addr=%h, want valid=0 ask=1 addr=%h",
                     name, if_valid, ic_mem_ask, ic_mem_addr, waddr);
         end
         dropped = 1'b0;
         for (int c = 0; c <= delay; c++) begin
            if (c == rdy_at) begin
               rdy_in    = 1'b0;
               rob_clear = 1'b1;
               for (int k = 0; k < 3; k++) begin
                  step();
                  n_tests++;
                  if (ic_mem_ask !== 1'b1 || ic_mem_addr !== waddr || if_valid !== 1'b0) begin
                     n_fail++;
                     $display("FAIL %s rdy_hold: ask=%b addr=%h valid=%b, want ask=1 addr=%h valid=0",
                              name, ic_mem_ask, ic_mem_addr, if_valid, waddr);
                  end
               end
               rdy_in    = 1'b1;
               rob_clear = 1'b0;
            end
            if (c == flush_at) begin
               rob_clear = 1'b1;
               if_req    = 1'b0;
               dropped   = 1'b1;
            end
            if (c == delay) begin
               ic_mem_valid = 1'b1;
               ic_mem_inst  = word;
            end
            step();
            rob_clear    = 1'b0;
            ic_mem_valid = 1'b0;
            ic_mem_inst  = $urandom;
            if (c < delay) begin
               n_tests++;
               if (ic_mem_ask !== 1'b1 || ic_mem_addr !== waddr || if_valid !== 1'b0) begin
                  n_fail++;
                  $display("FAIL %s miss_hold c=%0d: ask=%b addr=%h valid=%b, want ask=1 addr=%h valid=0",
                           name, c, ic_mem_ask, ic_mem_addr, if_valid, waddr);
               end
            end
         end
         mv[idx] = 1'b1;
         mt[idx] = tag;
         md[idx] = word;
         n_tests++;
         if (if_valid !== !dropped || ic_mem_ask !== 1'b0 || (!dropped && if_inst !== word)) begin
            n_fail++;
            $display("FAIL %s fill: valid=%b ask=%b inst=%h, want valid=%b ask=0 inst=%h",
                     name, if_valid, ic_mem_ask, if_inst, !dropped, word);
         end
         if_req = 1'b0;
      end
      step();
      n_tests++;
      if (if_valid !== 1'b0 || ic_mem_ask !== 1'b0) begin
         n_fail++;
         $display("FAIL %s pulse_end: valid=%b ask=%b, want 0 0", name, if_valid, ic_mem_ask);
      end
   endtask

   task automatic test_reset();
      rst_in       = 1'b0;
      rdy_in       = 1'b1;
      rob_clear    = 1'b0;
      if_req       = 1'b0;
      if_addr      = '0;
      ic_mem_valid = 1'b0;
      ic_mem_inst  = '0;
      model_clear();
      repeat (2) @(posedge clk_in);
      #1;
      n_tests++;
      if (if_valid !== 1'b0 || if_inst !== 32'h0 || ic_mem_ask !== 1'b0 || ic_mem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset: valid=%b inst=%h ask=%b addr=%h, want all zero",
                  if_valid, if_inst, ic_mem_ask, ic_mem_addr);
      end
      @(negedge clk_in);
      rst_in = 1'b1;
      step();
   endtask

   task automatic test_cold_miss();
      mem_word[32'h10] = 32'h0010_0093;
      do_fetch(32'h0000_0010, 6, -1, -1, "cold_miss");
   endtask

   task automatic test_hit();
      do_fetch(32'h0000_0010, 0, -1, -1, "hit");
      do_fetch(32'h0000_0013, 0, -1, -1, "hit_low_bits");
   endtask

   task automatic test_conflict();
      do_fetch(32'h0000_0050, 3, -1, -1, "conflict_b");
      do_fetch(32'h0000_0010, 2, -1, -1, "conflict_a");
   endtask

   task automatic test_flush_miss();
      mem_word[32'h20] = 32'h0000_0013;
      do_fetch(32'h0000_0020, 4, 2, -1, "flush_miss");
      do_fetch(32'h0000_0020, 0, -1, -1, "flush_refetch");
      do_fetch(32'h0000_0024, 3, 3, -1, "flush_coincident");
      do_fetch(32'h0000_0024, 0, -1, -1, "flush_coincident_hit");
   endtask

   task automatic test_flush_idle();
      if_req    = 1'b1;
      if_addr   = 32'h0000_0010;
      rob_clear = 1'b1;
      step();
      rob_clear = 1'b0;
      if_req    = 1'b0;
      n_tests++;
      if (if_valid !== 1'b0 || ic_mem_ask !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_idle: valid=%b ask=%b, want 0 0", if_valid, ic_mem_ask);
      end
      step();
   endtask

   task automatic test_long_wait();
      do_fetch(32'h0000_0030, 20, -1, 8, "long_wait");
   endtask

   task automatic test_reset_mid_miss();
      if_req  = 1'b1;
      if_addr = 32'h0000_0044;
      repeat (3) step();
      if_req = 1'b0;
      #2;
      rst_in = 1'b0;
      #1;
      n_tests++;
      if (ic_mem_ask !== 1'b0 || ic_mem_addr !== 32'h0 || if_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_miss: ask=%b addr=%h valid=%b, want 0 0 0",
                  ic_mem_ask, ic_mem_addr, if_valid);
      end
      model_clear();
      @(negedge clk_in);
      rst_in = 1'b1;
      // A late response for the abandoned miss must not fill anything.
      ic_mem_valid = 1'b1;
      ic_mem_inst  = 32'hDEAD_BEEF;
      step();
      ic_mem_valid = 1'b0;
      do_fetch(32'h0000_0010, 1, -1, -1, "after_reset_a");
      do_fetch(32'h0000_0044, 1, -1, -1, "after_reset_b");
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         int d, f;
         a = {24'h0, ($urandom_range(0, 2) * 64) + ($urandom_range(0, NL - 1) * 4)} |
             32'($urandom_range(0, 3));
         d = $urandom_range(0, 5);
         f = ($urandom_range(0, 4) == 0) ? $urandom_range(0, d) : -1;
         do_fetch(a, d, f, -1, "random");
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit();
      test_conflict();
      test_flush_miss();
      test_flush_idle();
      test_long_wait();
      test_reset_mid_miss();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
